// File: rtl/fifo_ctrl.sv
// Write arbiter, consumer handshake and flush sequencer for the circular-buffer FIFO datapath.
// Optional almost-full watermark output is built only when FIFO_CTRL_WATERMARK_EN is defined.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int PAR_WRITE  = 1,
    parameter int PAR_READ   = 1
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AF_LEVEL   = 12
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             in_valid,
    output logic [1:0]             in_ready,
    output logic                   wr_sel,
    output logic                   write_enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   read_enable,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [$clog2(SIZE):0]  count,
    output logic [1:0]             state
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    output logic                   almost_full
`endif
);

    localparam int CW = $clog2(SIZE) + 1;

    localparam logic [CW:0]   SIZE_X = (CW+1)'(SIZE);
    localparam logic [CW:0]   PW_X   = (CW+1)'(PAR_WRITE);
    localparam logic [CW-1:0] PW_C   = CW'(PAR_WRITE);
    localparam logic [CW-1:0] PR_C   = CW'(PAR_READ);

    if (DATA_WIDTH < 1 || (SIZE & (SIZE - 1)) != 0 || PAR_WRITE > SIZE || PAR_READ > SIZE) begin : g_bad_cfg
        $error("fifo_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          rr_q;
    logic          flush_done_q;

    logic full;
    logic empty;
    logic flushing;
    logic req_any;
    logic grant;
    logic wr_ok;

    // Sum is one bit wider than the count so SIZE + PAR_WRITE never wraps.
    assign full     = ({1'b0, count_q} + PW_X) > SIZE_X;
    assign empty    = count_q < PR_C;
    assign flushing = (state_q == FLUSH);

    assign req_any  = |in_valid;
    assign grant    = in_valid[rr_q] ? rr_q : ~rr_q;
    assign wr_sel   = req_any ? grant : rr_q;

    // A flush request wins over a write offered in the same cycle.
    assign wr_ok    = req_any & ~full & ~flushing & ~flush;

    assign in_ready[0]  = wr_ok & (grant == 1'b0);
    assign in_ready[1]  = wr_ok & (grant == 1'b1);
    assign write_enable = |(in_valid & in_ready);

    assign out_valid   = ~empty & (state_q == RUN);
    assign read_enable = (out_valid & out_ready) | (flushing & ~empty);

    always_comb begin
        count_d = count_q;
        if (write_enable) begin
            count_d = count_d + PW_C;
        end
        if (read_enable) begin
            count_d = count_d - PR_C;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            rr_q         <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            flush_done_q <= 1'b0;
            if (write_enable) begin
                rr_q <= ~grant;
            end
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q <= FLUSH;
                    end else if (write_enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q <= FLUSH;
                    end else if (count_d == '0) begin
                        state_q <= IDLE;
                    end
                end
                FLUSH: begin
                    if (empty) begin
                        state_q      <= IDLE;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flush_done = flush_done_q;
    assign count      = count_q;
    assign state      = state_q;

`ifdef FIFO_CTRL_WATERMARK_EN
    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);

    logic almost_full_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_d >= AF_C);
        end
    end

    assign almost_full = almost_full_q;
`endif

endmodule
